// File: rtl/fill_mon_pkg.sv
// Shared types and defaults for the thermometer fill monitor.
package fill_mon_pkg;

  localparam int FILL_WIDTH = 8;
  localparam int FILL_HOLD  = 4;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    FULL,
    CLEAR,
    DRAIN
  } fill_state_t;

endpackage

// File: rtl/therm_decode.sv
// Combinational thermometer-code check: legal when the code is 2^k-1,
// count is the number of ones (only meaningful when legal).
module therm_decode #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_code,
  output logic             o_legal,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] w_inc;

  // code+1 is a power of two (or wraps to zero) exactly for 2^k-1
  assign w_inc   = i_code + WIDTH'(1);
  assign o_legal = ((i_code & w_inc) == '0);

  // Population count of the sampled code
  always_comb begin
    o_count = '0;
    for (int i = 0; i < WIDTH; i++)
      o_count = o_count + CW'(i_code[i]);
  end

endmodule

// File: rtl/shift_fill_monitor.sv
// Monitors a falling-edge thermometer shifter: tracks fill level, flags
// illegal codes, counts completed fills and requests a shifter clear.
module shift_fill_monitor
  import fill_mon_pkg::*;
#(
  parameter int WIDTH       = FILL_WIDTH,
  parameter int HOLD_CYCLES = FILL_HOLD,
  parameter int CNT_W       = 8,
  parameter int LW          = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] therm,
  input  logic             enable,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             fill_done,
  output logic             clear_req,
  output logic [CNT_W-1:0] fill_count,
  output logic             code_err
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);

  fill_state_t      r_state, w_next;
  logic [HW-1:0]    r_hold;
  logic [WIDTH-1:0] r_therm_q;
  logic [LW-1:0]    r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             w_legal;
  logic [LW-1:0]    w_count;
  logic             w_drop;

  therm_decode #(.WIDTH(WIDTH), .CW(LW)) u_dec (
    .i_code  (r_therm_q),
    .o_legal (w_legal),
    .o_count (w_count)
  );

  // A legal sample lower than the current level while filling is an error
  assign w_drop = (r_state == FILL) && w_legal && (w_count < r_level) && !clear_req;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; once FULL is reached the clear sequence always finishes
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (enable) w_next = FILL;
      FILL: begin
        if (&r_therm_q)   w_next = FULL;
        else if (!enable) w_next = IDLE;
      end
      FULL:  w_next = CLEAR;
      CLEAR: if (r_hold == HW'(1)) w_next = DRAIN;
      DRAIN: if (r_therm_q == '0) w_next = enable ? FILL : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Hold down-counter: loaded in FULL, counts out the CLEAR cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               r_hold <= '0;
    else if (r_state == FULL)                r_hold <= HW'(HOLD_CYCLES);
    else if (r_state == CLEAR && r_hold != '0) r_hold <= r_hold - HW'(1);
  end

  // Sample the shifter, then update level / sticky error from the sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_therm_q <= '0;
      r_level   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_therm_q <= therm;
      if (w_legal) r_level <= w_count;
      r_err <= r_err | ~w_legal | w_drop;
    end
  end

  // Completed-fill counter, wraps freely
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                r_cnt <= '0;
    else if (r_state == FULL) r_cnt <= r_cnt + CNT_W'(1);
  end

  // Pulses decoded from the state register only
  assign full       = (r_state == FULL);
  assign fill_done  = (r_state == FULL);
  assign clear_req  = (r_state == CLEAR);
  assign level      = r_level;
  assign fill_count = r_cnt;
  assign code_err   = r_err;

endmodule
